// File: rtl/fx2_fifo_sched.sv
// fx2_fifo_sched
//   Arbitrates the FX2 slave-FIFO bus between three streams: command bytes
//   read from the host OUT endpoint, register reply bytes and timetag sample
//   records written to host IN endpoints. Manages FIFOADR / bus-direction
//   turnaround, record-aligned sample bursts, PKTEND after a reply and flushing
//   of a partial sample packet after an idle period.
//
// Ports
//   fx2_clk, reset        sole clock, synchronous active-high reset
//   fx2_flags[2:0]        [0] cmd EP not empty, [1] reply EP not full,
//                         [2] sample EP not full (active-high)
//   fx2_fd_in/out/oe      FD bus input, output, output enable (1 = FPGA drives)
//   fx2_fifoadr           endpoint select
//   fx2_slrd/slwr/sloe/pktend  active-low FX2 strobes
//   cmd_data/valid/ready  command byte stream to the register parser
//   reply_data/valid/end/ready  reply byte stream from the register block
//   sample_data/valid/ready     sample byte stream from the sample packer
module fx2_fifo_sched #(
  parameter logic [1:0]  CMD_EP       = 2'b00,
  parameter logic [1:0]  REPLY_EP     = 2'b10,
  parameter logic [1:0]  SAMPLE_EP    = 2'b11,
  parameter int unsigned RECORD_BYTES = 6,
  parameter int unsigned SAMPLE_BURST = 512,
  parameter int unsigned PKT_BYTES    = 512,
  parameter int unsigned FLUSH_CYCLES = 4096
) (
  input  logic       fx2_clk,
  input  logic       reset,
  input  logic [2:0] fx2_flags,
  input  logic [7:0] fx2_fd_in,
  output logic [7:0] fx2_fd_out,
  output logic       fx2_fd_oe,
  output logic [1:0] fx2_fifoadr,
  output logic       fx2_slrd,
  output logic       fx2_slwr,
  output logic       fx2_sloe,
  output logic       fx2_pktend,
  output logic [7:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  input  logic [7:0] reply_data,
  input  logic       reply_valid,
  input  logic       reply_end,
  output logic       reply_ready,
  input  logic [7:0] sample_data,
  input  logic       sample_valid,
  output logic       sample_ready
);

  localparam int unsigned REC_W   = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
  localparam int unsigned PKT_W   = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int unsigned BURST_W = $clog2(SAMPLE_BURST + 1);
  localparam int unsigned IDLE_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [REC_W-1:0]   REC_LAST  = REC_W'(RECORD_BYTES - 1);
  localparam logic [PKT_W-1:0]   PKT_LAST  = PKT_W'(PKT_BYTES - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(SAMPLE_BURST);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_RD,
    S_WR_REPLY,
    S_WR_SAMPLE,
    S_PKTEND
  } state_t;

  state_t state;
  state_t target;        // state entered after a TURN cycle
  logic   dir_out;       // bus direction of the last grant: 1 = FPGA writes

  logic [REC_W-1:0]   rec_cnt;
  logic [PKT_W-1:0]   pkt_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [IDLE_W-1:0]  idle_cnt;

  // Request qualification
  logic cmd_req, reply_req, sample_req, flush_due;
  logic rd_fire, reply_fire, sample_fire, sample_exit, flush_take;

  assign cmd_req    = fx2_flags[0] & cmd_ready;
  assign reply_req  = reply_valid & fx2_flags[1];
  assign sample_req = sample_valid & fx2_flags[2];
  assign flush_due  = (idle_cnt == IDLE_MAX) && (rec_cnt == '0) && (pkt_cnt != '0);

  // A sample grant is released either to a competing request (at a record
  // boundary once the burst minimum is met, or at once when the sample EP is
  // full) or to a pending flush. On the release cycle no byte is accepted, so
  // a flag drop coinciding with the yield never produces a strobe.
  assign sample_exit = (state == S_WR_SAMPLE) &&
                       (flush_due ||
                        ((cmd_req || reply_req) &&
                         (((burst_cnt >= BURST_MAX) && (rec_cnt == '0)) || !fx2_flags[2])));

  assign rd_fire      = (state == S_RD) && cmd_req;
  assign reply_ready  = (state == S_WR_REPLY) && fx2_flags[1];
  assign sample_ready = (state == S_WR_SAMPLE) && fx2_flags[2] && !sample_exit;
  assign reply_fire   = reply_ready && reply_valid;
  assign sample_fire  = sample_ready && sample_valid;

  // Data strobes follow the same-cycle handshake; everything that only
  // depends on the grant (sloe, fd_oe, fifoadr, pktend) is registered below.
  assign fx2_slrd   = !rd_fire;
  assign fx2_slwr   = !(reply_fire || sample_fire);
  assign fx2_fd_out = (state == S_WR_SAMPLE) ? sample_data : reply_data;

  // IDLE arbitration
  logic       pick_valid;
  logic [1:0] pick_adr;
  logic       pick_out;
  state_t     pick_state;

  always_comb begin
    pick_valid = 1'b0;
    pick_adr   = fx2_fifoadr;
    pick_out   = dir_out;
    pick_state = S_IDLE;
    if (cmd_req) begin
      pick_valid = 1'b1;
      pick_adr   = CMD_EP;
      pick_out   = 1'b0;
      pick_state = S_RD;
    end else if (reply_req) begin
      pick_valid = 1'b1;
      pick_adr   = REPLY_EP;
      pick_out   = 1'b1;
      pick_state = S_WR_REPLY;
    end else if (sample_req) begin
      pick_valid = 1'b1;
      pick_adr   = SAMPLE_EP;
      pick_out   = 1'b1;
      pick_state = S_WR_SAMPLE;
    end else if (flush_due) begin
      pick_valid = 1'b1;
      pick_adr   = SAMPLE_EP;
      pick_out   = 1'b1;
      pick_state = S_PKTEND;
    end
  end

  assign flush_take = (state == S_IDLE) && pick_valid && (pick_state == S_PKTEND);

  // Registered output values on entering a granted state, shared by the
  // direct IDLE path and the TURN path.
  state_t entry_state;
  logic   entry_sloe, entry_oe, entry_pktend;

  always_comb begin
    entry_state  = (state == S_TURN) ? target : pick_state;
    entry_sloe   = (entry_state != S_RD);
    entry_oe     = (entry_state == S_WR_REPLY) || (entry_state == S_WR_SAMPLE);
    entry_pktend = (entry_state != S_PKTEND);
  end

  // Bus FSM
  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      target      <= S_IDLE;
      dir_out     <= 1'b0;
      fx2_fifoadr <= CMD_EP;
      fx2_sloe    <= 1'b1;
      fx2_pktend  <= 1'b1;
      fx2_fd_oe   <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_data    <= '0;
    end else begin
      cmd_valid <= rd_fire;
      if (rd_fire) begin
        cmd_data <= fx2_fd_in;
      end

      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            fx2_fifoadr <= pick_adr;
            dir_out     <= pick_out;
            if ((pick_adr != fx2_fifoadr) || (pick_out != dir_out)) begin
              state  <= S_TURN;
              target <= pick_state;
            end else begin
              state      <= pick_state;
              fx2_sloe   <= entry_sloe;
              fx2_fd_oe  <= entry_oe;
              fx2_pktend <= entry_pktend;
            end
          end
        end

        S_TURN: begin
          state      <= target;
          fx2_sloe   <= entry_sloe;
          fx2_fd_oe  <= entry_oe;
          fx2_pktend <= entry_pktend;
        end

        S_RD: begin
          if (!cmd_req) begin
            state    <= S_IDLE;
            fx2_sloe <= 1'b1;
          end
        end

        S_WR_REPLY: begin
          if (reply_fire && reply_end) begin
            state      <= S_PKTEND;
            fx2_pktend <= 1'b0;
            fx2_fd_oe  <= 1'b0;
          end
        end

        S_WR_SAMPLE: begin
          if (sample_exit) begin
            state     <= S_IDLE;
            fx2_fd_oe <= 1'b0;
          end
        end

        S_PKTEND: begin
          state      <= S_IDLE;
          fx2_pktend <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Sample stream bookkeeping. rec_cnt survives a mid-record yield so the
  // record resumes on the next grant; the packet/idle counts are cleared in
  // the cycle the flush wins arbitration so it cannot re-trigger.
  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      rec_cnt   <= '0;
      pkt_cnt   <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      if (sample_fire) begin
        rec_cnt  <= (rec_cnt == REC_LAST) ? '0 : rec_cnt + REC_W'(1);
        pkt_cnt  <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PKT_W'(1);
        idle_cnt <= '0;
        if (burst_cnt != BURST_MAX) begin
          burst_cnt <= burst_cnt + BURST_W'(1);
        end
      end else if (flush_take) begin
        pkt_cnt  <= '0;
        idle_cnt <= '0;
      end else if ((pkt_cnt != '0) && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end

      // A fresh sample grant starts a new burst.
      if ((state != S_WR_SAMPLE) && (entry_state == S_WR_SAMPLE) &&
          ((state == S_TURN) || ((state == S_IDLE) && pick_valid))) begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fx2_fifo_sched.sv
// tb_fx2_fifo_sched
//   Self-checking bench for fx2_fifo_sched: a cycle-by-cycle vector table
//   covering reset state, a command read and a terminated reply, followed by
//   hand-written sequences for burst yield, mid-record yield, idle flush,
//   full-packet wrap and reset mid-burst. Inputs change on the falling edge,
//   outputs are sampled 1 ns later.
module tb_fx2_fifo_sched;

  localparam int FLUSH = 16;
  localparam int BURST = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] flags = '0;
  logic [7:0] fd_in = '0;
  logic [7:0] fd_out;
  logic       fd_oe;
  logic [1:0] fifoadr;
  logic       slrd, slwr, sloe, pktend;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [7:0] reply_data = '0;
  logic       reply_valid = 1'b0;
  logic       reply_end = 1'b0;
  logic       reply_ready;
  logic [7:0] sample_data = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;

  always #5 clk = ~clk;

  fx2_fifo_sched #(
    .SAMPLE_BURST(BURST),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .fx2_clk      (clk),
    .reset        (reset),
    .fx2_flags    (flags),
    .fx2_fd_in    (fd_in),
    .fx2_fd_out   (fd_out),
    .fx2_fd_oe    (fd_oe),
    .fx2_fifoadr  (fifoadr),
    .fx2_slrd     (slrd),
    .fx2_slwr     (slwr),
    .fx2_sloe     (sloe),
    .fx2_pktend   (pktend),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .reply_data   (reply_data),
    .reply_valid  (reply_valid),
    .reply_end    (reply_end),
    .reply_ready  (reply_ready),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
  );

  int n_vec = 0;
  int n_bad = 0;
  int clash = 0;

  // FPGA driving FD while the FX2 output enable is active is never allowed.
  always @(negedge clk) begin
    #2;
    if (fd_oe && !sloe) clash++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] flags;
    logic       crdy;
    logic [7:0] fdin;
    logic       rv;
    logic [7:0] rdat;
    logic       rend;
    logic [3:0] e_str;   // {slrd, sloe, slwr, pktend}
    logic       e_oe;
    logic [1:0] e_adr;
    logic       e_cv;
    logic [7:0] e_cd;    // checked only when e_cv
    logic       e_rr;
    logic [7:0] e_fdo;   // checked only when e_oe
  } vec_t;

  function automatic vec_t mk(input logic [2:0] f, input logic cr, input logic [7:0] fi,
                              input logic rv, input logic [7:0] rd, input logic re,
                              input logic [3:0] s, input logic oe, input logic [1:0] a,
                              input logic cv, input logic [7:0] cd, input logic rr,
                              input logic [7:0] fo);
    vec_t v;
    v.flags = f; v.crdy = cr; v.fdin = fi; v.rv = rv; v.rdat = rd; v.rend = re;
    v.e_str = s; v.e_oe = oe; v.e_adr = a; v.e_cv = cv; v.e_cd = cd; v.e_rr = rr;
    v.e_fdo = fo;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    automatic int writes, sent, rsent, reply_pk, last, pkat, pkcount;
    automatic logic got_rd, pk, sample_pk, rd_oe, rd_sloe;
    automatic logic [1:0] rd_adr, pk_adr;
    automatic logic [7:0] first_resume;
    automatic int dbad;

    // Command read of AA 01 03 00 04 00 00 00 straight from reset (no turn:
    // EP 00 and read direction are the reset selection), then a 4-byte reply
    // on EP 10 with a turn cycle, PKTEND and return to IDLE.
    vecs[0]  = mk(3'b000, 0, 8'h00, 0, 8'h00, 0, 4'b1111, 0, 2'b00, 0, 8'h00, 0, 8'h00);
    vecs[1]  = mk(3'b001, 1, 8'hAA, 0, 8'h00, 0, 4'b1111, 0, 2'b00, 0, 8'h00, 0, 8'h00);
    vecs[2]  = mk(3'b001, 1, 8'hAA, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 0, 8'h00, 0, 8'h00);
    vecs[3]  = mk(3'b001, 1, 8'h01, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'hAA, 0, 8'h00);
    vecs[4]  = mk(3'b001, 1, 8'h03, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'h01, 0, 8'h00);
    vecs[5]  = mk(3'b001, 1, 8'h00, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'h03, 0, 8'h00);
    vecs[6]  = mk(3'b001, 1, 8'h04, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'h00, 0, 8'h00);
    vecs[7]  = mk(3'b001, 1, 8'h00, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'h04, 0, 8'h00);
    vecs[8]  = mk(3'b001, 1, 8'h00, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'h00, 0, 8'h00);
    vecs[9]  = mk(3'b001, 1, 8'h00, 0, 8'h00, 0, 4'b0011, 0, 2'b00, 1, 8'h00, 0, 8'h00);
    vecs[10] = mk(3'b000, 1, 8'h00, 0, 8'h00, 0, 4'b1011, 0, 2'b00, 1, 8'h00, 0, 8'h00);
    vecs[11] = mk(3'b010, 0, 8'h00, 1, 8'h78, 0, 4'b1111, 0, 2'b00, 0, 8'h00, 0, 8'h00);
    vecs[12] = mk(3'b010, 0, 8'h00, 1, 8'h78, 0, 4'b1111, 0, 2'b10, 0, 8'h00, 0, 8'h00);
    vecs[13] = mk(3'b010, 0, 8'h00, 1, 8'h78, 0, 4'b1101, 1, 2'b10, 0, 8'h00, 1, 8'h78);
    vecs[14] = mk(3'b010, 0, 8'h00, 1, 8'h56, 0, 4'b1101, 1, 2'b10, 0, 8'h00, 1, 8'h56);
    vecs[15] = mk(3'b010, 0, 8'h00, 1, 8'h34, 0, 4'b1101, 1, 2'b10, 0, 8'h00, 1, 8'h34);
    vecs[16] = mk(3'b010, 0, 8'h00, 1, 8'h12, 1, 4'b1101, 1, 2'b10, 0, 8'h00, 1, 8'h12);
    vecs[17] = mk(3'b010, 0, 8'h00, 0, 8'h00, 0, 4'b1110, 0, 2'b10, 0, 8'h00, 0, 8'h00);
    vecs[18] = mk(3'b010, 0, 8'h00, 0, 8'h00, 0, 4'b1111, 0, 2'b10, 0, 8'h00, 0, 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      flags = vecs[i].flags; cmd_ready = vecs[i].crdy; fd_in = vecs[i].fdin;
      reply_valid = vecs[i].rv; reply_data = vecs[i].rdat; reply_end = vecs[i].rend;
      #1;
      n_vec++;
      if ({slrd, sloe, slwr, pktend} !== vecs[i].e_str || fd_oe !== vecs[i].e_oe ||
          fifoadr !== vecs[i].e_adr || cmd_valid !== vecs[i].e_cv ||
          (vecs[i].e_cv && cmd_data !== vecs[i].e_cd) || reply_ready !== vecs[i].e_rr ||
          sample_ready !== 1'b0 || (vecs[i].e_oe && fd_out !== vecs[i].e_fdo)) begin
        n_bad++;
        $display("FAIL vec%0d: got str=%b oe=%b adr=%b cv=%b cd=%h rr=%b sr=%b fdo=%h, expected str=%b oe=%b adr=%b cv=%b cd=%h rr=%b sr=0 fdo=%h",
                 i, {slrd, sloe, slwr, pktend}, fd_oe, fifoadr, cmd_valid, cmd_data,
                 reply_ready, sample_ready, fd_out, vecs[i].e_str, vecs[i].e_oe,
                 vecs[i].e_adr, vecs[i].e_cv, vecs[i].e_cd, vecs[i].e_rr, vecs[i].e_fdo);
      end
    end
    reply_valid = 1'b0; reply_end = 1'b0;

    // Burst yield: command appears after sample byte 3; the grant is kept
    // until the 12-byte burst minimum at a record boundary, then TURN to RD.
    writes = 0; got_rd = 0; dbad = 0; rd_adr = 2'b11; rd_oe = 1; rd_sloe = 1;
    for (int c = 0; c < 80 && !got_rd; c++) begin
      @(negedge clk);
      flags = {2'b11, writes >= 3}; cmd_ready = (writes >= 3);
      sample_valid = 1'b1; sample_data = 8'(8'h40 + writes); fd_in = 8'h5A;
      #1;
      if (!slwr && fifoadr == 2'b11) begin
        if (fd_out !== sample_data || !fd_oe) dbad++;
        writes++;
      end
      if (!slrd) begin
        got_rd = 1; rd_adr = fifoadr; rd_oe = fd_oe; rd_sloe = sloe;
      end
    end
    chk("burst_rd_reached", 32'(got_rd), 1);
    chk("burst_bytes", 32'(writes), BURST);
    chk("burst_data", 32'(dbad), 0);
    chk("burst_rd_adr", 32'(rd_adr), 0);
    chk("burst_rd_sloe_oe", {rd_sloe, rd_oe}, 0);
    @(negedge clk);
    flags = 3'b110; cmd_ready = 1'b0; sample_valid = 1'b0;
    #1;
    chk("burst_cmd_byte", {cmd_valid, cmd_data}, {1'b1, 8'h5A});

    // The 12 buffered sample bytes form a partial packet: flushed on EP 11.
    pk = 0; pk_adr = 2'b00;
    for (int c = 0; c < 80 && !pk; c++) begin
      @(negedge clk);
      #1;
      if (!pktend) begin pk = 1; pk_adr = fifoadr; end
    end
    chk("leftover_flush", {pk, pk_adr}, {1'b1, 2'b11});

    // Idle flush: 6 bytes then idle. The idle count reaches 16 after the
    // 16th idle cycle, the grant drops next cycle, IDLE picks the flush and
    // PKTEND shows in the following cycle: last write + 19.
    sent = 0; last = -1; pkat = -1; pk_adr = 2'b00;
    for (int c = 0; c < 80 && pkat < 0; c++) begin
      @(negedge clk);
      sample_valid = (sent < 6); sample_data = 8'(sent);
      #1;
      if (sample_valid && sample_ready) begin sent++; last = c; end
      if (!pktend) begin pkat = c; pk_adr = fifoadr; end
    end
    chk("flush_bytes", 32'(sent), 6);
    chk("flush_delay", 32'(pkat - last), FLUSH + 3);
    chk("flush_adr", 32'(pk_adr), 2'b11);

    // Mid-record yield: sample EP fills after record byte 3 while a reply
    // waits; the reply goes out and the record resumes at byte 4. Finishing
    // the record lets the partial packet flush, which needs rec alignment.
    sent = 0; rsent = 0; reply_pk = 0; sample_pk = 0; first_resume = 8'h00; dbad = 0;
    for (int c = 0; c < 120 && !sample_pk; c++) begin
      @(negedge clk);
      flags = {!(sent == 3 && rsent < 2), 2'b10};
      reply_valid = (sent >= 3 && rsent < 2);
      reply_data = 8'(8'hC1 + rsent); reply_end = (rsent == 1);
      sample_valid = (sent < 6); sample_data = 8'(8'hB0 + sent);
      #1;
      if (!slwr && fifoadr == 2'b10) begin
        if (fd_out !== reply_data) dbad++;
        rsent++;
      end
      if (!slwr && fifoadr == 2'b11) begin
        if (sent == 3) first_resume = fd_out;
        sent++;
      end
      if (!pktend && fifoadr == 2'b10) reply_pk++;
      if (!pktend && fifoadr == 2'b11) sample_pk = 1;
    end
    reply_valid = 1'b0; reply_end = 1'b0; sample_valid = 1'b0; flags = 3'b110;
    chk("yield_reply_bytes", 32'(rsent), 2);
    chk("yield_reply_data", 32'(dbad), 0);
    chk("yield_reply_pktend", 32'(reply_pk), 1);
    chk("yield_resume_byte", 32'(first_resume), 8'hB3);
    chk("yield_sample_bytes", 32'(sent), 6);
    chk("yield_record_flush", 32'(sample_pk), 1);

    // Exactly one full packet: the counter wraps and nothing is flushed.
    sent = 0; pkcount = 0;
    for (int c = 0; c < 800 && sent < 512; c++) begin
      @(negedge clk);
      sample_valid = 1'b1; sample_data = 8'(c);
      #1;
      if (sample_valid && sample_ready) sent++;
      if (!pktend) pkcount++;
    end
    for (int c = 0; c < FLUSH + 14; c++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      #1;
      if (!pktend) pkcount++;
    end
    chk("full_pkt_bytes", 32'(sent), 512);
    chk("full_pkt_no_pktend", 32'(pkcount), 0);

    // Reset mid-burst: 4 more bytes complete the record left open by the
    // 512-byte run, so without the reset a flush would follow.
    sent = 0;
    for (int c = 0; c < 40 && sent < 4; c++) begin
      @(negedge clk);
      sample_valid = 1'b1; sample_data = 8'(c);
      #1;
      if (sample_valid && sample_ready) sent++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; sample_valid = 1'b0;
    #1;
    chk("reset_outputs",
        {slrd, sloe, slwr, pktend, fd_oe, fifoadr, reply_ready, sample_ready, cmd_valid},
        {4'b1111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
    pkcount = 0;
    for (int c = 0; c < FLUSH + 14; c++) begin
      @(negedge clk);
      #1;
      if (!pktend) pkcount++;
    end
    chk("reset_discards_packet", 32'(pkcount), 0);
    chk("bus_never_shared", 32'(clash), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
